// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Brief   : Iterative RV32M/RV64M multiply/divide unit. A shift-add
//           multiplier and a restoring divider each produce one bit per
//           cycle. Operands are converted to magnitudes on entry and the
//           signs are reapplied in a single fixup cycle.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] C_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  // r_hi: product high half / partial remainder
  // r_lo: multiplier shifting out, product low half / dividend in, quotient out
  // r_opb: multiplicand magnitude / divisor magnitude
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opb;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_b_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_sub;
  logic              w_ge;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix;

  // Operand signedness by opcode; MUL is treated as signed since its low half is sign-agnostic
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'b010:  w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_a_neg   = w_a_signed & a[XLEN-1];
  assign w_b_neg   = w_b_signed & b[XLEN-1];
  assign w_a_mag   = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag   = w_b_neg ? (~b + 1'b1) : b;
  assign w_b_zero  = (b == '0);
  assign w_div_ovf = ~funct3[0] & (a == C_MOST_NEG) & (&b);
  assign w_special = funct3[2] & (w_b_zero | w_div_ovf);

  // Early-out results for divide-by-zero and signed overflow
  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = funct3[1] ? a : '1;
    end else if (!funct3[1]) begin
      w_special_res = a;
    end
  end

  // One multiply step: conditionally add multiplicand into the high half, then shift right
  assign w_addend = r_lo[0] ? r_opb : '0;
  assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};

  // One restoring-divide step; the remainder always stays below the divisor,
  // so the borrow of the trial subtraction alone decides the quotient bit
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_sub   = w_shift - {1'b0, r_opb};
  assign w_ge    = ~w_sub[XLEN];

  assign w_cnt_nxt = r_cnt - CNT_W'(1);

  // Sign fixup and result selection
  assign w_prod_s = r_neg_res ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
  assign w_quo    = r_neg_res ? (~r_lo + 1'b1) : r_lo;
  assign w_rem    = r_neg_rem ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    w_fix = '0;
    case (r_op)
      3'b000:                 w_fix = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix = w_quo;
      default:                w_fix = w_rem;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opb     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start && !kill) begin
            r_op      <= funct3;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= CNT_W'(XLEN);
            r_busy    <= 1'b1;
            r_hi      <= '0;
            if (funct3[2]) begin
              r_lo  <= w_a_mag;
              r_opb <= w_b_mag;
            end else begin
              r_lo  <= w_b_mag;
              r_opb <= w_a_mag;
            end
            if (w_special) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (r_op[2]) begin
              r_hi <= w_ge ? w_sub[XLEN-1:0] : w_shift[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], w_ge};
            end else begin
              r_hi <= w_sum[XLEN:1];
              r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == '0) begin
              r_state <= S_FIXUP;
            end
          end
        end
        S_FIXUP: begin
          if (kill) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_result <= w_fix;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
`default_nettype wire
